uart_rx: RTL

- Multi-lane UART receiver. It is the downstream stage of uart_tx on the chiplet PHY link.
- Samples PORTCOUNT parallel serial lanes, detects the shared start bit, and deserialises 2, 4 or 10 bit-times of lane data.
- Checks start and stop framing, then presents a PORTCOUNT*10-bit word with its comma code to the link layer as a one-cycle done pulse.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// Multi-lane UART receiver: 2-flop lane synchroniser, shared start-bit detect,
// 2/4/10 bit-time deserialiser selected by the comma code, with framing checks.
module uart_rx #(
  parameter int PORTCOUNT    = 5,
  parameter int CLKDIV_W     = 10,
  parameter int CLKDIV_COUNT = 10
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [PORTCOUNT-1:0]   uart_in,
  output logic [PORTCOUNT*10-1:0] data,
  output logic [1:0]             comma_sel,
  output logic                   done,
  output logic                   rx_err,
  output logic                   busy,
  output logic [2:0]             dbg_state_o
);

  localparam int DW = PORTCOUNT * 10;
  localparam logic [CLKDIV_W-1:0] DIV_LAST = CLKDIV_W'(CLKDIV_COUNT - 1);
  localparam logic [CLKDIV_W-1:0] DIV_HALF = CLKDIV_W'(CLKDIV_COUNT / 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t                state_q;
  logic [PORTCOUNT-1:0]  sync1_q;
  logic [PORTCOUNT-1:0]  s_in_q;
  logic [CLKDIV_W-1:0]   div_q;
  logic [CLKDIV_W-1:0]   bit_cnt_q;
  logic [CLKDIV_W-1:0]   nbits_q;
  logic [DW-1:0]         shift_q;
  logic [DW-1:0]         data_q;
  logic [1:0]            code_q;
  logic [1:0]            comma_q;
  logic                  done_q;

  logic                  all0;
  logic                  all1;
  logic                  sample_tick;
  logic [CLKDIV_W-1:0]   div_inc;
  logic [CLKDIV_W-1:0]   bit_cnt_inc;

  assign all0        = (s_in_q == '0);
  assign all1        = (s_in_q == '1);
  assign sample_tick = (div_q == DIV_LAST);
  assign div_inc     = sample_tick ? '0 : div_q + CLKDIV_W'(1);
  assign bit_cnt_inc = bit_cnt_q + CLKDIV_W'(1);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= '1;
      s_in_q  <= '1;
    end else begin
      sync1_q <= uart_in;
      s_in_q  <= sync1_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      nbits_q   <= '0;
      shift_q   <= '1;
      data_q    <= '1;
      code_q    <= '0;
      comma_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          shift_q <= '1;
          // Loading half a bit-time puts the first tick at mid start bit.
          if (!all1) begin
            state_q <= ST_START;
            div_q   <= DIV_HALF;
          end
        end
        ST_START: begin
          div_q <= div_inc;
          if (sample_tick) begin
            if (all0) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end else if (all1) begin
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_ERROR;
              div_q   <= '0;
            end
          end
        end
        ST_DATA: begin
          div_q <= div_inc;
          if (sample_tick) begin
            for (int k = 0; k < 10; k++) begin
              if (bit_cnt_q == CLKDIV_W'(k)) shift_q[k*PORTCOUNT +: PORTCOUNT] <= s_in_q;
            end
            bit_cnt_q <= bit_cnt_inc;
            if (bit_cnt_q == '0) begin
              code_q <= s_in_q[1:0];
              case (s_in_q[1:0])
                2'd1:    nbits_q <= CLKDIV_W'(2);
                2'd2:    nbits_q <= CLKDIV_W'(4);
                2'd3:    nbits_q <= CLKDIV_W'(10);
                default: begin
                  nbits_q <= '0;
                  state_q <= ST_ERROR;
                  div_q   <= '0;
                end
              endcase
            end else if (bit_cnt_inc == nbits_q) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          div_q <= div_inc;
          if (sample_tick) begin
            if (all1) begin
              data_q    <= shift_q;
              comma_q   <= code_q;
              done_q    <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              state_q <= ST_ERROR;
              div_q   <= '0;
            end
          end
        end
        ST_ERROR: begin
          // div_q doubles as the count of consecutive all-high cycles here.
          if (!all1) begin
            div_q <= '0;
          end else if (div_q == DIV_LAST) begin
            state_q <= ST_IDLE;
          end else begin
            div_q <= div_q + CLKDIV_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data        = data_q;
  assign comma_sel   = comma_q;
  assign done        = done_q;
  assign rx_err      = (state_q == ST_ERROR);
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
